nvme_pl_credit_rx: RTL and testbench

//  Receive end of a credit-flow pipelined link: absorbs a push-only valid/data stream (no

---
 rtl/nvme_pl_credit_rx_if.sv | 26 ++
 rtl/nvme_pl_credit_rx.sv | 101 ++++++++++
 tb/tb_nvme_pl_credit_rx.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/nvme_pl_credit_rx_if.sv
// Link-side bundle for the credit-flow receiver: push-only inbound stream,
// credit return, valid/ready outbound stream and status flags.
interface nvme_pl_credit_rx_if #(
  parameter int WIDTH = 128
);
  logic             valid_in;
  logic [WIDTH-1:0] data_in;
  logic             credit_out;
  logic             valid_out;
  logic [WIDTH-1:0] data_out;
  logic             ready_in;
  logic             init_done;
  logic             error_out;

  // receiver side
  modport master (
    input  valid_in, data_in, ready_in,
    output credit_out, valid_out, data_out, init_done, error_out
  );

  // sender/consumer side
  modport slave (
    output valid_in, data_in, ready_in,
    input  credit_out, valid_out, data_out, init_done, error_out
  );
endinterface

// File: rtl/nvme_pl_credit_rx.sv
// Credit-flow link receiver: push-only stream into a FWFT FIFO, one credit pulse per freed entry.
// Optional overflow/protocol checking enabled by defining NVME_PL_CREDIT_RX_CHK_EN.
//
// state   | meaning
// ST_INIT | issuing the DEPTH initial credits after reset
// ST_RUN  | all initial credits issued; terminal until reset
module nvme_pl_credit_rx #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  nvme_pl_credit_rx_if.master  bus
);
  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1
  } state_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      pend_q, pend_d;
  logic [AW:0]      init_cnt_q, init_cnt_d;
  logic             credit_q, credit_d;
  state_e           state_q, state_d;
  logic             empty, full, push, pop, wr_en, emit;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign push  = bus.valid_in;
  assign pop   = !empty && bus.ready_in;
  assign emit  = (pend_q != '0);

`ifdef NVME_PL_CREDIT_RX_CHK_EN
  logic err_q, err_d, ovf;
  // second term: sender pushed while every credit is still held here
  assign ovf   = push && (full || ((pend_q == DEPTH_C) && empty));
  assign wr_en = push && !full;
  assign err_d = err_q || ovf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign bus.error_out = err_q;
`else
  assign wr_en         = push;
  assign bus.error_out = 1'b0;
`endif

  assign wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  assign pend_d   = pend_q - (AW+1)'(emit) + (AW+1)'(pop);
  assign credit_d = emit;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pend_q     <= DEPTH_C;
      credit_q   <= 1'b0;
      init_cnt_q <= '0;
      state_q    <= ST_INIT;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pend_q     <= pend_d;
      credit_q   <= credit_d;
      init_cnt_q <= init_cnt_d;
      state_q    <= state_d;
    end
  end

  // Counts every emitted credit while in INIT, so pop credits queued early also count.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == DEPTH_C) state_d = ST_RUN;
        else                       init_cnt_d = init_cnt_q + (AW+1)'(emit);
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  assign bus.credit_out = credit_q;
  assign bus.valid_out  = !empty;
  assign bus.data_out   = mem_q[rd_ptr_q[AW-1:0]];
  assign bus.init_done  = (state_q == ST_RUN);
endmodule

// File: tb/tb_nvme_pl_credit_rx.sv
// Directed bench for nvme_pl_credit_rx (DEPTH=8, WIDTH=128): credit start-up,
// fill/drain table, streaming, optional overflow check and mid-operation reset.
module tb_nvme_pl_credit_rx;
  localparam int W = 128;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         r;
    logic         ev;
    logic [W-1:0] ed;
    logic         ec;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cred_cnt = 0;
  int   push_cnt = 0;
  int   pop_cnt = 0;
  vec_t tbl[$];

  nvme_pl_credit_rx_if #(.WIDTH(W)) bus ();

  nvme_pl_credit_rx #(.WIDTH(W), .DEPTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (reset_n && bus.credit_out) cred_cnt++;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
    bus.valid_in = v;
    bus.data_in  = d;
    bus.ready_in = r;
  endtask

  // Release reset at the current negedge and follow the 8 initial credits.
  task automatic init_seq();
    reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("init_credit_c%0d", k), W'(bus.credit_out), W'(k <= 8));
      chk($sformatf("init_done_c%0d", k), W'(bus.init_done), W'(k >= 9));
    end
  endtask

  function automatic logic [W-1:0] beat(input int i);
    return {4{32'(i * 37 + 5)}};
  endfunction

  initial begin
    drive(1'b0, '0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_valid", W'(bus.valid_out), W'(0));
    chk("rst_credit", W'(bus.credit_out), W'(0));
    chk("rst_init_done", W'(bus.init_done), W'(0));
    chk("rst_error", W'(bus.error_out), W'(0));
    init_seq();

    // fill 8 without pops, then drain 8; credit shows two cycles after each pop
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b1, W'(8'hA0 + i), 1'b0, i > 0, W'(8'hA0), 1'b0});
    tbl.push_back('{1'b0, '0, 1'b0, 1'b1, W'(8'hA0), 1'b0});
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b0, '0, 1'b1, 1'b1, W'(8'hA0 + i), i >= 2});
    tbl.push_back('{1'b0, '0, 1'b0, 1'b0, '0, 1'b1});
    tbl.push_back('{1'b0, '0, 1'b0, 1'b0, '0, 1'b1});
    tbl.push_back('{1'b0, '0, 1'b0, 1'b0, '0, 1'b0});
    foreach (tbl[i]) begin
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), W'(bus.valid_out), W'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), bus.data_out, tbl[i].ed);
      chk($sformatf("tbl%0d_credit", i), W'(bus.credit_out), W'(tbl[i].ec));
      drive(tbl[i].v, tbl[i].d, tbl[i].r);
      if (tbl[i].v) push_cnt++;
      if (tbl[i].r && tbl[i].ev) pop_cnt++;
    end

    // streaming: one push and one pop per cycle, occupancy 1
    for (int i = 0; i <= 103; i++) begin
      @(negedge clk);
      chk($sformatf("strm%0d_valid", i), W'(bus.valid_out), W'(i >= 1 && i <= 100));
      if (i >= 1 && i <= 100) chk($sformatf("strm%0d_data", i), bus.data_out, beat(i - 1));
      chk($sformatf("strm%0d_credit", i), W'(bus.credit_out), W'(i >= 3 && i <= 102));
      drive(i < 100, (i < 100) ? beat(i) : '0, i >= 1 && i <= 100);
      if (i < 100) push_cnt++;
      if (i >= 1 && i <= 100) pop_cnt++;
    end

`ifdef NVME_PL_CREDIT_RX_CHK_EN
    // overflow: push while full with a simultaneous pop is dropped
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      chk($sformatf("ovf%0d_valid", i), W'(bus.valid_out), W'(i >= 1 && i <= 15));
      if (i >= 1 && i <= 15)
        chk($sformatf("ovf%0d_data", i), bus.data_out, W'(8'hF0 + ((i <= 8) ? 0 : i - 8)));
      chk($sformatf("ovf%0d_error", i), W'(bus.error_out), W'(i >= 9));
      if (i < 8) drive(1'b1, W'(8'hF0 + i), 1'b0);
      else if (i == 8) drive(1'b1, W'(8'hFF), 1'b1);
      else drive(1'b0, '0, i <= 15);
      if (i < 8) push_cnt++;
      if (i >= 8 && i <= 15) pop_cnt++;
    end
`endif

    drive(1'b0, '0, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    chk("err_flag_end", W'(bus.error_out),
`ifdef NVME_PL_CREDIT_RX_CHK_EN
        W'(1)
`else
        W'(0)
`endif
    );
    chk("credits_total", W'(cred_cnt), W'(8 + pop_cnt));
    chk("sender_holds_all", W'(cred_cnt - push_cnt), W'(8));

    // mid-operation reset with entries and pending credits
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(1'b1, beat(200 + i), 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b0, '0, 1'b1);
    end
    @(negedge clk);
    drive(1'b0, '0, 1'b0);
    chk("pre_rst_valid", W'(bus.valid_out), W'(1));
    chk("pre_rst_data", bus.data_out, beat(202));
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", W'(bus.valid_out), W'(0));
    chk("midrst_credit", W'(bus.credit_out), W'(0));
    chk("midrst_init_done", W'(bus.init_done), W'(0));
    @(negedge clk);
    init_seq();
    chk("post_rst_valid", W'(bus.valid_out), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
